// File: rtl/shift_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_pkg
// Description : Shared types for the shift-add multiplier controller and its
//               datapath: FSM state encoding, datapath strobe bundle and the
//               bit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_add_pkg;

    // Default operand width used when the controller is not overridden.
    localparam int c_N_DEFAULT = 8;

    // Bit-counter width able to hold the value n (counter is loaded with N).
    function automatic int calc_cw(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } shift_add_state_t;

    // Strobes consumed by the multiplier datapath.
    typedef struct packed {
        logic ld_regs;
        logic add_en;
        logic shift_en;
    } shift_add_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/shift_add_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_ctrl_counter
// Description : Loadable saturating up/down counter used as the iteration
//               counter of the shift-add controller.
//   clk         in   clock
//   rst         in   asynchronous active-high reset (count clears to 0)
//   load_i      in   load data_in_i (priority over en_i)
//   data_in_i   in   N  load value
//   up_down_i   in   1 = count up, 0 = count down
//   en_i        in   count enable
//   data_out_o  out  N  current count
//   end_flag_o  out  count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_ctrl_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] data_in_i,
    input  logic         up_down_i,
    input  logic         en_i,
    output logic [N-1:0] data_out_o,
    output logic         end_flag_o
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    // Saturates at both ends: never wraps below 0 or above all-ones.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = data_in_i;
        end else if (en_i) begin
            if (up_down_i) begin
                if (count_q != '1) begin
                    count_d = count_q + N'(1);
                end
            end else if (count_q != '0) begin
                count_d = count_q - N'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign data_out_o = count_q;
    assign end_flag_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/shift_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_ctrl
// Description : Sequencing controller for an N-bit shift-add multiplier.
//               Accepts start/ready requests, owns the iteration counter and
//               drives the datapath load / add / shift strobes.
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   start_i      in   request a multiplication (accepted only while ready)
//   abort_i      in   cancel the operation in flight (beats start)
//   q0_i         in   LSB of the datapath multiplier register
//   q_zero_i     in   datapath multiplier register is all zero
//   ready_o      out  controller idle
//   busy_o       out  operation in flight (inverse of ready_o)
//   done_o       out  one-cycle pulse, product valid in the datapath
//   ld_regs_o    out  load operands, clear accumulator
//   add_en_o     out  accumulator += multiplicand
//   shift_en_o   out  shift accumulator/multiplier pair right by one
//   bits_left_o  out  CW  current iteration count
// Configuration:
//   SHIFT_ADD_EARLY_EXIT_EN - when defined, CHECK finishes as soon as
//   q_zero_i is high; otherwise q_zero_i is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_ctrl
    import shift_add_pkg::*;
#(
    parameter int N  = c_N_DEFAULT,
    parameter int CW = calc_cw(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          q0_i,
    input  logic          q_zero_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          ld_regs_o,
    output logic          add_en_o,
    output logic          shift_en_o,
    output logic [CW-1:0] bits_left_o
);

    shift_add_state_t state_q;
    shift_add_state_t state_d;
    shift_add_ctrl_t  w_strb;
    logic             w_done;
    logic             w_cnt_load;
    logic             w_cnt_end;

`ifndef SHIFT_ADD_EARLY_EXIT_EN
    // Port kept for a uniform interface; unused without early exit.
    logic w_unused_q_zero;
    assign w_unused_q_zero = q_zero_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes depend on state only, so an async reset clears them at once.
    // The counter load is the one Mealy term (start accepted in IDLE).
    always_comb begin
        state_d    = state_q;
        w_strb     = '0;
        w_done     = 1'b0;
        w_cnt_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    w_cnt_load = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_strb.ld_regs = 1'b1;
                state_d        = ST_CHECK;
            end
            ST_CHECK: begin
`ifdef SHIFT_ADD_EARLY_EXIT_EN
                if (q_zero_i) begin
                    state_d = ST_DONE;
                end else
`endif
                if (w_cnt_end) begin
                    state_d = ST_DONE;
                end else if (q0_i) begin
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_ADD: begin
                w_strb.add_en = 1'b1;
                state_d       = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_strb.shift_en = 1'b1;
                state_d         = ST_CHECK;
            end
            ST_DONE: begin
                w_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Down-counter: loaded with N on accept, decremented once per SHIFT.
    shift_add_ctrl_counter #(
        .N (CW)
    ) counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_cnt_load),
        .data_in_i  (CW'(N)),
        .up_down_i  (1'b0),
        .en_i       (state_q == ST_SHIFT),
        .data_out_o (bits_left_o),
        .end_flag_o (w_cnt_end)
    );

    assign ready_o    = (state_q == ST_IDLE);
    assign busy_o     = ~ready_o;
    assign done_o     = w_done;
    assign ld_regs_o  = w_strb.ld_regs;
    assign add_en_o   = w_strb.add_en;
    assign shift_en_o = w_strb.shift_en;

endmodule
`default_nettype wire
